stream_reorder_arb: RTL and testbench

// - Shares one streaming-reorder datapath ({<< N {x}} / {>> N {x}}) between NREQ requesters.
// - Provides round-robin arbitration with packet lock, and per-requester reorder configuration.
// - Registers the output with valid/ready backpressure.
// - Sits between packet sources and a single downstream consumer of bit/slice-reordered words.

---
 rtl/stream_reorder_arb_pkg.sv | 17 +
 rtl/stream_reorder_arb_if.sv | 40 ++++
 rtl/stream_reorder_arb_slice_rev.sv | 30 +++
 rtl/stream_reorder_arb.sv | 127 ++++++++++++
 tb/tb_stream_reorder_arb.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/stream_reorder_arb_pkg.sv
// Shared types for the stream reorder arbiter.
// Arbiter state, per-requester reorder config, slice-code width.
package stream_reorder_pkg;

  localparam int SLW = 3;

  typedef enum logic {
    ARB,
    LOCK
  } arb_state_t;

  typedef struct packed {
    logic           dir;
    logic [SLW-1:0] slice;
  } reorder_cfg_t;

endpackage

// File: rtl/stream_reorder_arb_if.sv
// Handshake bundle between requesters/consumer and the arbiter.
// master drives requests and out_ready; slave is the arbiter.
interface stream_reorder_arb_if #(
  parameter int WIDTH = 32,
  parameter int NREQ  = 2,
  parameter int SLW   = 3
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_last;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       req_ready;
  logic                  cfg_we;
  logic [IDW-1:0]        cfg_id;
  logic                  cfg_dir;
  logic [SLW-1:0]        cfg_slice;
  logic                  out_valid;
  logic                  out_ready;
  logic [WIDTH-1:0]      out_data;
  logic [IDW-1:0]        out_id;
  logic                  out_last;

  modport master (
    output req_valid, req_last, req_data,
    output cfg_we, cfg_id, cfg_dir, cfg_slice,
    output out_ready,
    input  req_ready,
    input  out_valid, out_data, out_id, out_last
  );

  modport slave (
    input  req_valid, req_last, req_data,
    input  cfg_we, cfg_id, cfg_dir, cfg_slice,
    input  out_ready,
    output req_ready,
    output out_valid, out_data, out_id, out_last
  );

endinterface

// File: rtl/stream_reorder_arb_slice_rev.sv
// Combinational slice-order reversal of one word.
// Slices are 2**slice_i bits; dir_i=0 or oversize slices pass through.
module stream_slice_rev #(
  parameter int WIDTH = 32,
  parameter int SLW   = 3
) (
  input  logic [WIDTH-1:0] in_i,
  input  logic             dir_i,
  input  logic [SLW-1:0]   slice_i,
  output logic [WIDTH-1:0] out_o
);
  localparam int LW = $clog2(WIDTH);

  logic [LW-1:0] mask;

  // Reversing power-of-two slices flips the slice-index bits of each bit position
  always_comb begin
    mask = '0;
    if (dir_i && (int'(slice_i) < LW))
      mask = ~LW'((32'd1 << slice_i) - 32'd1);
  end

  // Gather every output bit from its mirrored source position
  always_comb begin
    out_o = '0;
    for (int i = 0; i < WIDTH; i++)
      out_o[i] = in_i[LW'(i) ^ mask];
  end

endmodule

// File: rtl/stream_reorder_arb.sv
// Round-robin arbiter with packet lock sharing one reorder datapath.
// Output word is registered with valid/ready backpressure.
module stream_reorder_arb #(
  parameter int WIDTH = 32,
  parameter int NREQ  = 2,
  parameter int SLW   = 3
) (
  input logic           clk,
  input logic           rst_n,
  stream_reorder_arb_if.slave bus
);
  import stream_reorder_pkg::*;

  localparam int IDW = $clog2(NREQ);

  arb_state_t       state_q;
  logic [IDW-1:0]   lock_q;
  logic [IDW-1:0]   rr_q;
  reorder_cfg_t     cfg_q [NREQ];
  reorder_cfg_t     snap_q;
  logic             out_valid_q;
  logic             out_last_q;
  logic [WIDTH-1:0] out_data_q;
  logic [IDW-1:0]   out_id_q;

  logic [IDW-1:0]   gnt;
  logic             gnt_vld;
  logic             can_take;
  logic             acc;
  logic [NREQ-1:0]  ready;
  reorder_cfg_t     eff;
  logic [WIDTH-1:0] gnt_data;
  logic             gnt_last;
  logic [WIDTH-1:0] rev;

  function automatic logic [IDW-1:0] wrap(input int v);
    return IDW'((v >= NREQ) ? v - NREQ : v);
  endfunction

  // Pick the locked owner, or the first valid requester from rr_q onward
  always_comb begin
    gnt     = rr_q;
    gnt_vld = 1'b0;
    if (state_q == LOCK) begin
      gnt     = lock_q;
      gnt_vld = bus.req_valid[lock_q];
    end else begin
      for (int k = NREQ - 1; k >= 0; k--) begin
        if (bus.req_valid[wrap(int'(rr_q) + k)]) begin
          gnt     = wrap(int'(rr_q) + k);
          gnt_vld = 1'b1;
        end
      end
    end
  end

  assign can_take = !out_valid_q || bus.out_ready;
  assign acc      = gnt_vld && can_take;
  assign eff      = (state_q == LOCK) ? snap_q : cfg_q[gnt];
  assign gnt_data = bus.req_data[int'(gnt)*WIDTH +: WIDTH];
  assign gnt_last = bus.req_last[gnt];

  // One-hot ready to the granted requester, held low during reset
  always_comb begin
    ready = '0;
    if (acc && rst_n)
      ready[gnt] = 1'b1;
  end

  stream_slice_rev #(
    .WIDTH (WIDTH),
    .SLW   (SLW)
  ) u_rev (
    .in_i    (gnt_data),
    .dir_i   (eff.dir),
    .slice_i (eff.slice),
    .out_o   (rev)
  );

  // Arbiter FSM, config table and registered output stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ARB;
      lock_q      <= '0;
      rr_q        <= '0;
      snap_q      <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      out_id_q    <= '0;
      for (int i = 0; i < NREQ; i++)
        cfg_q[i] <= '0;
    end else begin
      if (bus.cfg_we && (int'(bus.cfg_id) < NREQ))
        cfg_q[bus.cfg_id] <= '{dir: bus.cfg_dir, slice: bus.cfg_slice};
      if (acc) begin
        out_valid_q <= 1'b1;
        out_data_q  <= rev;
        out_id_q    <= gnt;
        out_last_q  <= gnt_last;
        unique case (state_q)
          ARB: begin
            rr_q <= wrap(int'(gnt) + 1);
            if (!gnt_last) begin
              state_q <= LOCK;
              lock_q  <= gnt;
              snap_q  <= cfg_q[gnt];
            end
          end
          LOCK: begin
            if (gnt_last)
              state_q <= ARB;
          end
        endcase
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.req_ready = ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_id    = out_id_q;
  assign bus.out_last  = out_last_q;

endmodule

// File: tb/tb_stream_reorder_arb.sv
// Scoreboard bench for stream_reorder_arb (WIDTH=32, NREQ=2).
// Reference model predicts grants and reordered words per cycle.
module tb_stream_reorder_arb;

  localparam int W   = 32;
  localparam int N   = 2;
  localparam int S   = 3;
  localparam int IDW = 1;

  typedef struct {
    logic [W-1:0] d;
    logic         l;
  } beat_t;

  typedef struct {
    logic [W-1:0] d;
    int           id;
    logic         l;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  stream_reorder_arb_if #(.WIDTH(W), .NREQ(N), .SLW(S)) bus ();

  stream_reorder_arb #(.WIDTH(W), .NREQ(N), .SLW(S)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [N-1:0]   vld;
  logic [N-1:0]   lst;
  logic [W-1:0]   dat [N];
  logic           oready;
  logic           cwe;
  logic [IDW-1:0] cid;
  logic           cdir;
  logic [S-1:0]   csl;
  logic [N-1:0]   acc;
  bit             rnd;

  assign bus.req_valid = vld;
  assign bus.req_last  = lst;
  assign bus.cfg_we    = cwe;
  assign bus.cfg_id    = cid;
  assign bus.cfg_dir   = cdir;
  assign bus.cfg_slice = csl;
  assign bus.out_ready = oready;

  for (genvar g = 0; g < N; g++) begin : g_data
    assign bus.req_data[g*W +: W] = dat[g];
  end

  beat_t        pq [N][$];
  exp_t         sb [$];
  int           seen_id [$];
  logic [W-1:0] seen_d [$];

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] a,
                     input logic [63:0] e);
    n_cmp++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
    end
  endtask

  task automatic fail_now(input string nm);
    n_cmp++;
    n_err++;
    $display("FAIL %s: timed out at %0t", nm, $time);
  endtask

  function automatic logic [W-1:0] rev_model(input logic [W-1:0] x,
                                             input logic dir,
                                             input logic [S-1:0] code);
    int sz;
    int m;
    logic [W-1:0] r;
    sz = 1 << code;
    if (!dir || sz >= W) return x;
    m = W / sz;
    r = '0;
    for (int k = 0; k < m; k++)
      for (int b = 0; b < sz; b++)
        r[(m-1-k)*sz + b] = x[k*sz + b];
    return r;
  endfunction

  function automatic logic [W-1:0] bsw(input logic [W-1:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  // reference model state
  bit           m_lock;
  int           m_lid;
  int           m_rr;
  bit           m_outv;
  logic         m_cdir [N];
  logic [S-1:0] m_csl [N];
  logic         m_sdir;
  logic [S-1:0] m_ssl;

  always @(negedge rst_n) begin
    m_lock = 0;
    m_lid  = 0;
    m_rr   = 0;
    m_outv = 0;
    m_sdir = 0;
    m_ssl  = '0;
    for (int i = 0; i < N; i++) begin
      m_cdir[i] = 1'b0;
      m_csl[i]  = '0;
    end
    sb.delete();
  end

  always @(negedge clk) begin : model
    int g;
    bit gv;
    bit can;
    logic [N-1:0] er;
    logic ed;
    logic [S-1:0] es;
    if (!rst_n) begin
      acc = '0;
    end else begin
      can = !m_outv || oready;
      gv  = 0;
      g   = 0;
      if (m_lock) begin
        g  = m_lid;
        gv = vld[g];
      end else begin
        for (int k = 0; k < N; k++) begin
          if (!gv && vld[(m_rr + k) % N]) begin
            g  = (m_rr + k) % N;
            gv = 1;
          end
        end
      end
      er = (gv && can) ? N'(1 << g) : '0;
      chk("out_valid", 64'(bus.out_valid), 64'(m_outv));
      chk("req_ready", 64'(bus.req_ready), 64'(er));
      acc = vld & bus.req_ready;
      if (gv && can) begin
        ed = m_lock ? m_sdir : m_cdir[g];
        es = m_lock ? m_ssl : m_csl[g];
        sb.push_back('{rev_model(dat[g], ed, es), g, lst[g]});
        m_outv = 1;
        if (!m_lock) begin
          m_rr = (g + 1) % N;
          if (!lst[g]) begin
            m_lock = 1;
            m_lid  = g;
            m_sdir = m_cdir[g];
            m_ssl  = m_csl[g];
          end
        end else if (lst[g]) begin
          m_lock = 0;
        end
      end else if (oready) begin
        m_outv = 0;
      end
      if (cwe) begin
        m_cdir[cid] = cdir;
        m_csl[cid]  = csl;
      end
    end
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && bus.out_valid && oready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL sb_empty: unexpected word %0h id %0d",
                 bus.out_data, bus.out_id);
      end else begin
        e = sb.pop_front();
        chk("out_data", 64'(bus.out_data), 64'(e.d));
        chk("out_id", 64'(bus.out_id), 64'(e.id));
        chk("out_last", 64'(bus.out_last), 64'(e.l));
      end
      seen_id.push_back(int'(bus.out_id));
      seen_d.push_back(bus.out_data);
    end
  end

  task automatic cyc();
    beat_t b;
    int len;
    @(posedge clk);
    #1;
    cwe = 1'b0;
    if (rnd) begin
      oready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) begin
        cwe  = 1'b1;
        cid  = IDW'($urandom_range(0, N - 1));
        cdir = 1'($urandom_range(0, 1));
        csl  = S'($urandom_range(0, 7));
      end
      for (int i = 0; i < N; i++) begin
        if (pq[i].size() == 0 && $urandom_range(0, 1) == 0) begin
          len = $urandom_range(1, 4);
          for (int j = 0; j < len; j++)
            pq[i].push_back('{$urandom(), (j == len - 1)});
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!vld[i] || acc[i]) begin
        if (pq[i].size() > 0 && !(rnd && $urandom_range(0, 3) == 0)) begin
          b      = pq[i].pop_front();
          vld[i] = 1'b1;
          dat[i] = b.d;
          lst[i] = b.l;
        end else begin
          vld[i] = 1'b0;
        end
      end
    end
  endtask

  task automatic wait_out(input string nm);
    for (int t = 0; t < 20 && !bus.out_valid; t++)
      cyc();
    if (!bus.out_valid)
      fail_now(nm);
  endtask

  task automatic drain(input string nm);
    bit done;
    done = 0;
    for (int t = 0; t < 400 && !done; t++) begin
      if (pq[0].size() == 0 && pq[1].size() == 0 && vld == '0 &&
          sb.size() == 0 && !bus.out_valid)
        done = 1;
      else
        cyc();
    end
    if (!done)
      fail_now(nm);
  endtask

  task automatic set_cfg(input int id, input logic dir,
                         input logic [S-1:0] sl);
    cwe  = 1'b1;
    cid  = IDW'(id);
    cdir = dir;
    csl  = sl;
    cyc();
  endtask

  task automatic vec(input string nm, input logic dir,
                     input logic [S-1:0] sl, input logic [W-1:0] din,
                     input logic [W-1:0] dout);
    set_cfg(0, dir, sl);
    pq[0].push_back('{din, 1'b1});
    wait_out(nm);
    chk(nm, 64'(bus.out_data), 64'(dout));
    chk({nm, "_id"}, 64'(bus.out_id), 64'd0);
    drain(nm);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] a, b, c, d, e, f, hold;
    vld    = '0;
    lst    = '0;
    dat[0] = '0;
    dat[1] = '0;
    oready = 1'b1;
    cwe    = 1'b0;
    cid    = '0;
    cdir   = 1'b0;
    csl    = '0;
    acc    = '0;
    rnd    = 0;

    repeat (3) @(posedge clk);
    #1;
    vld = 2'b11;
    #1;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_data", 64'(bus.out_data), 64'd0);
    chk("rst_out_id", 64'(bus.out_id), 64'd0);
    chk("rst_out_last", 64'(bus.out_last), 64'd0);
    chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
    vld = '0;
    #1;
    rst_n = 1'b1;
    cyc();

    vec("rev_bit", 1'b1, 3'd0, 32'h04030201, 32'h8040C020);
    vec("rev_byte", 1'b1, 3'd3, 32'h04030201, 32'h01020304);
    vec("rev_pair", 1'b1, 3'd1, 32'h00000001, 32'h40000000);
    vec("rev_s32", 1'b1, 3'd5, 32'h00000001, 32'h00000001);
    vec("rev_s128", 1'b1, 3'd7, 32'h00000001, 32'h00000001);
    vec("pass_dir0", 1'b0, 3'd0, 32'h04030201, 32'h04030201);

    pq[1].push_back('{$urandom(), 1'b1});
    drain("rr_align");

    seen_id.delete();
    for (int k = 0; k < 3; k++) begin
      pq[0].push_back('{$urandom(), 1'b1});
      pq[1].push_back('{$urandom(), 1'b1});
    end
    drain("rr");
    chk("rr_count", 64'(seen_id.size()), 64'd6);
    for (int k = 0; k < seen_id.size(); k++)
      chk("rr_order", 64'(seen_id[k]), 64'(k % 2));

    set_cfg(0, 1'b1, 3'd3);
    seen_id.delete();
    seen_d.delete();
    a = $urandom();
    b = $urandom();
    c = $urandom();
    d = $urandom();
    pq[0].push_back('{a, 1'b0});
    pq[0].push_back('{b, 1'b0});
    pq[0].push_back('{c, 1'b1});
    pq[1].push_back('{d, 1'b1});
    cyc();
    cyc();
    cwe  = 1'b1;
    cid  = '0;
    cdir = 1'b0;
    csl  = '0;
    cyc();
    drain("lock");
    chk("lock_count", 64'(seen_id.size()), 64'd4);
    if (seen_id.size() == 4) begin
      chk("lock_id0", 64'(seen_id[0]), 64'd0);
      chk("lock_id1", 64'(seen_id[1]), 64'd0);
      chk("lock_id2", 64'(seen_id[2]), 64'd0);
      chk("lock_id3", 64'(seen_id[3]), 64'd1);
      chk("lock_d0", 64'(seen_d[0]), 64'(bsw(a)));
      chk("lock_d1", 64'(seen_d[1]), 64'(bsw(b)));
      chk("lock_d2", 64'(seen_d[2]), 64'(bsw(c)));
      chk("lock_d3", 64'(seen_d[3]), 64'(d));
    end
    e = $urandom();
    pq[0].push_back('{e, 1'b1});
    drain("lock_next");
    chk("lock_newcfg", 64'(seen_d[seen_d.size()-1]), 64'(e));

    seen_d.delete();
    for (int k = 0; k < 4; k++)
      pq[0].push_back('{$urandom(), 1'b1});
    wait_out("stall");
    oready = 1'b0;
    hold   = bus.out_data;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("stall_valid", 64'(bus.out_valid), 64'd1);
      chk("stall_data", 64'(bus.out_data), 64'(hold));
      chk("stall_ready", 64'(bus.req_ready), 64'd0);
    end
    oready = 1'b1;
    drain("stall_drain");
    chk("stall_count", 64'(seen_d.size()), 64'd4);

    rnd = 1;
    repeat (3000) cyc();
    rnd    = 0;
    oready = 1'b1;
    drain("random");

    seen_id.delete();
    seen_d.delete();
    for (int k = 0; k < 3; k++)
      pq[0].push_back('{$urandom(), (k == 2)});
    wait_out("rst_mid");
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_mid_ready", 64'(bus.req_ready), 64'd0);
    pq[0].delete();
    vld[0] = 1'b0;
    f = $urandom();
    pq[1].push_back('{f, 1'b1});
    cyc();
    #2;
    rst_n = 1'b1;
    #1;
    chk("rst_rel_ready", 64'(bus.req_ready), 64'(2'b10));
    drain("rst_rel");
    chk("rst_rel_id", 64'(seen_id[seen_id.size()-1]), 64'd1);
    chk("rst_rel_data", 64'(seen_d[seen_d.size()-1]), 64'(f));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
